// File: rtl/compuerta_pkg.sv
// Shared types and constants for the parking-gate access controller.
package compuerta_pkg;

  localparam int PIN_W = 8;
  localparam logic [PIN_W-1:0] PIN_DEF = 8'b0001_0000;

  typedef enum logic [2:0] {
    CERRADO    = 3'd0,
    ESPERA_PIN = 3'd1,
    ALARMA     = 3'd2,
    ABIERTO    = 3'd3,
    BLOQUEO    = 3'd4
  } estado_t;

endpackage

// File: rtl/detector_flanco.sv
// Registered rising-edge detector: one-cycle pulse on the first cycle d is high.
module detector_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulso
);

  logic q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

  assign pulso = d & ~q;

endmodule

// File: rtl/controlador_compuerta.sv
// Parking-gate controller: PIN check on enter-button edges, wrong-attempt alarm,
// tailgating lock. Moore outputs decoded from the registered state.
module controlador_compuerta
  import compuerta_pkg::*;
#(
  parameter logic [PIN_W-1:0] PIN_CORRECTO = PIN_DEF,
  parameter int               MAX_INTENTOS = 3,
  parameter int               CNT_W        = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Vehiculo,
  input  logic             Termino,
  input  logic             enterPin,
  input  logic [PIN_W-1:0] Pin,
  output logic             Cerrado,
  output logic             Abierto,
  output logic             Alarma,
  output logic             Bloqueo,
  output logic [CNT_W-1:0] Intentos
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INTENTOS);

  estado_t          est_q, est_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             press, ok, bad;

  detector_flanco u_flanco (
    .clk   (Clk),
    .rst_n (Reset),
    .d     (enterPin),
    .pulso (press)
  );

  assign ok  = press & (Pin == PIN_CORRECTO);
  assign bad = press & (Pin != PIN_CORRECTO);

  // Saturating increment: the count never wraps past the attempt limit.
  assign cnt_inc = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      est_q <= CERRADO;
      cnt_q <= '0;
    end else begin
      est_q <= est_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    est_d = est_q;
    cnt_d = cnt_q;
    case (est_q)
      CERRADO: if (Vehiculo) est_d = ESPERA_PIN;
      ESPERA_PIN: begin
        // A press wins over the vehicle leaving in the same cycle.
        if (ok) begin
          est_d = ABIERTO;
          cnt_d = '0;
        end else if (bad) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CNT_MAX) est_d = ALARMA;
        end else if (!Vehiculo) begin
          est_d = CERRADO;
          cnt_d = '0;
        end
      end
      ALARMA: begin
        if (ok) begin
          est_d = ABIERTO;
          cnt_d = '0;
        end else if (bad) begin
          cnt_d = cnt_inc;
        end
      end
      ABIERTO: if (Termino) est_d = Vehiculo ? BLOQUEO : CERRADO;
      BLOQUEO: if (ok) est_d = ABIERTO;
      default: begin
        est_d = CERRADO;
        cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    Cerrado = 1'b1;
    Abierto = 1'b0;
    Alarma  = 1'b0;
    Bloqueo = 1'b0;
    case (est_q)
      ALARMA: Alarma = 1'b1;
      ABIERTO: begin
        Cerrado = 1'b0;
        Abierto = 1'b1;
      end
      BLOQUEO: begin
        Alarma  = 1'b1;
        Bloqueo = 1'b1;
      end
      default: ;
    endcase
  end

  assign Intentos = cnt_q;

endmodule

// File: tb/tb_controlador_compuerta.sv
// Directed bench for controlador_compuerta with an expected-output scoreboard.
module tb_controlador_compuerta;

  localparam int S_CER = 0, S_ESP = 1, S_ALA = 2, S_ABI = 3, S_BLO = 4;

  logic       Clk = 1'b0;
  logic       Reset, Vehiculo, Termino, enterPin;
  logic [7:0] Pin;
  logic       Cerrado, Abierto, Alarma, Bloqueo;
  logic [1:0] Intentos;

  typedef struct {
    string      tag;
    logic [5:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 Clk = ~Clk;

  controlador_compuerta dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Vehiculo (Vehiculo),
    .Termino  (Termino),
    .enterPin (enterPin),
    .Pin      (Pin),
    .Cerrado  (Cerrado),
    .Abierto  (Abierto),
    .Alarma   (Alarma),
    .Bloqueo  (Bloqueo),
    .Intentos (Intentos)
  );

  // Expected {Cerrado, Abierto, Alarma, Bloqueo, Intentos} for a state and count.
  function automatic logic [5:0] st(int s, int c);
    logic [3:0] o;
    case (s)
      S_ALA:   o = 4'b1010;
      S_ABI:   o = 4'b0100;
      S_BLO:   o = 4'b1011;
      default: o = 4'b1000;
    endcase
    return {o, 2'(c)};
  endfunction

  task automatic expect_out(input string tag, input logic [5:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check();
    exp_t       e;
    logic [5:0] obs;
    e   = sb.pop_front();
    obs = {Cerrado, Abierto, Alarma, Bloqueo, Intentos};
    n_chk++;
    assert (obs === e.v) n_pass++;
    else $error("FAIL %s: got C/A/Al/B/Int=%b expected %b", e.tag, obs, e.v);
  endtask

  // Push expectation, let one rising edge happen, compare just after it.
  task automatic cycle(input string tag, input logic [5:0] v);
    expect_out(tag, v);
    @(posedge Clk);
    #1;
    check();
  endtask

  task automatic press(input string tag, input logic [7:0] p, input logic [5:0] v);
    enterPin = 1'b1;
    Pin      = p;
    cycle(tag, v);
    enterPin = 1'b0;
    cycle({tag, "_rel"}, v);
  endtask

  initial begin
    Reset = 1'b0; Vehiculo = 1'b0; Termino = 1'b0; enterPin = 1'b0; Pin = 8'h00;
    #2;
    expect_out("reset", st(S_CER, 0));
    check();
    @(negedge Clk);
    Reset = 1'b1;

    // Presses with no vehicle are ignored, then normal entry.
    press("press_novehicle", 8'h10, st(S_CER, 0));
    Vehiculo = 1'b1;
    cycle("vehicle", st(S_ESP, 0));
    press("pin_ok", 8'h10, st(S_ABI, 0));
    press("press_in_open", 8'hFF, st(S_ABI, 0));
    Vehiculo = 1'b0; Termino = 1'b1;
    cycle("termino_close", st(S_CER, 0));
    Termino = 1'b0;

    // Wrong-PIN limit and saturation.
    Vehiculo = 1'b1;
    cycle("vehicle2", st(S_ESP, 0));
    for (int i = 1; i <= 3; i++)
      press($sformatf("bad%0d", i), 8'hFF, st(i < 3 ? S_ESP : S_ALA, i));
    press("bad4_sat", 8'hFF, st(S_ALA, 3));
    Vehiculo = 1'b0;
    cycle("alarm_vehicle_gone", st(S_ALA, 3));
    press("alarm_ok", 8'h10, st(S_ABI, 0));
    Termino = 1'b1;
    cycle("close2", st(S_CER, 0));
    Termino = 1'b0;

    // Below the limit; vehicle leaving clears the count.
    Vehiculo = 1'b1;
    cycle("vehicle3", st(S_ESP, 0));
    press("bad_once", 8'h00, st(S_ESP, 1));
    Vehiculo = 1'b0;
    cycle("leave_clears", st(S_CER, 0));
    Vehiculo = 1'b1;
    cycle("vehicle4", st(S_ESP, 0));
    press("bad_once2", 8'h11, st(S_ESP, 1));
    press("ok_below", 8'h10, st(S_ABI, 0));

    // Tailgating lock.
    Termino = 1'b1;
    cycle("tailgate", st(S_BLO, 0));
    cycle("termino_in_lock", st(S_BLO, 0));
    Termino = 1'b0;
    press("lock_bad", 8'hFF, st(S_BLO, 0));
    press("lock_ok", 8'h10, st(S_ABI, 0));

    // Enter-edge rule: Pin changes alone do nothing; a held button counts once.
    Vehiculo = 1'b0; Termino = 1'b1;
    cycle("close3", st(S_CER, 0));
    Termino = 1'b0; Vehiculo = 1'b1;
    cycle("vehicle5", st(S_ESP, 0));
    for (int i = 0; i < 4; i++) begin
      Pin = (i % 2 == 0) ? 8'h10 : 8'h00;
      cycle($sformatf("pin_toggle%0d", i), st(S_ESP, 0));
    end
    enterPin = 1'b1; Pin = 8'h10;
    cycle("held_1", st(S_ABI, 0));
    cycle("held_2", st(S_ABI, 0));
    enterPin = 1'b0;
    cycle("held_rel", st(S_ABI, 0));

    // Async reset mid-period while open, with inputs active.
    #3;
    Reset = 1'b0;
    #1;
    expect_out("arst_open", st(S_CER, 0));
    check();
    enterPin = 1'b1; Pin = 8'h10;
    cycle("arst_hold1", st(S_CER, 0));
    cycle("arst_hold2", st(S_CER, 0));
    enterPin = 1'b0;
    Reset = 1'b1;

    // Async reset while locked.
    cycle("vehicle6", st(S_ESP, 0));
    press("ok6", 8'h10, st(S_ABI, 0));
    Termino = 1'b1;
    cycle("tailgate2", st(S_BLO, 0));
    Termino = 1'b0;
    #2;
    Reset = 1'b0;
    #1;
    expect_out("arst_lock", st(S_CER, 0));
    check();
    Reset = 1'b1;

    // Async reset clears a partial attempt count.
    cycle("vehicle7", st(S_ESP, 0));
    press("bad7a", 8'hFF, st(S_ESP, 1));
    press("bad7b", 8'hFF, st(S_ESP, 2));
    #2;
    Reset = 1'b0;
    #1;
    expect_out("arst_count", st(S_CER, 0));
    check();
    Reset = 1'b1;
    cycle("after_reset", st(S_ESP, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
